// File: rtl/arp_pkg.sv
// Shared ARP constants and state type used by the reply transmitter and
// the word packing helper.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam int          ARP_WORDS      = 7;
    localparam int          ARP_IDX_W      = 3;

    typedef enum logic {
        IDLE,
        SEND
    } arp_state_e;

endpackage

// File: rtl/arp_word_mux.sv
// Combinational packing of an ARP reply into 32-bit words. The sender
// fields are this node, the target fields are the peer being answered.
module arp_word_mux
    import arp_pkg::*;
(
    input  logic [ARP_IDX_W-1:0] idx_i,
    input  logic [47:0]          local_mac_i,
    input  logic [31:0]          local_ip_i,
    input  logic [47:0]          peer_mac_i,
    input  logic [31:0]          peer_ip_i,
    output logic [31:0]          word_o
);

    // Select the word for the given position in the seven-word packet.
    always_comb begin
        word_o = '0;
        case (idx_i)
            3'd0:    word_o = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4};
            3'd1:    word_o = {ARP_HLEN, ARP_PLEN, ARP_OP_REPLY};
            3'd2:    word_o = local_mac_i[47:16];
            3'd3:    word_o = {local_mac_i[15:0], local_ip_i[31:16]};
            3'd4:    word_o = {local_ip_i[15:0], peer_mac_i[47:32]};
            3'd5:    word_o = peer_mac_i[31:0];
            3'd6:    word_o = peer_ip_i;
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: checks each parsed packet against the request
// match rule for this node and streams a seven-word reply when it matches.
// All stream outputs are registered; the next word is chosen from the
// next-state index so tx_data lines up with tx_valid/tx_last.
module arp_reply_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35010203,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8010A,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [15:0]      rx_hdr_type,
    input  logic [15:0]      rx_proto_type,
    input  logic [7:0]       rx_hdr_addr_length,
    input  logic [7:0]       rx_pro_addr_length,
    input  logic [15:0]      rx_operation,
    input  logic [47:0]      rx_send_hdr_addr,
    input  logic [31:0]      rx_send_ip_addr,
    input  logic [31:0]      rx_target_ip_addr,
    output logic [31:0]      tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic [CNT_W-1:0] reply_cnt,
    output logic [CNT_W-1:0] ignore_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [ARP_IDX_W-1:0] LAST_IDX = ARP_IDX_W'(ARP_WORDS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    arp_state_e             state_q, state_d;
    logic [ARP_IDX_W-1:0]   idx_q, idx_d;
    logic [47:0]            mac_q, mac_d;
    logic [31:0]            ip_q, ip_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [31:0]            data_q, data_d;
    logic [CNT_W-1:0]       reply_q, reply_d;
    logic [CNT_W-1:0]       ignore_q, ignore_d;
    logic [CNT_W-1:0]       drop_q, drop_d;
    logic                   is_match;
    logic [31:0]            next_word;

    // Decide whether the presented packet is an ARP request for our IP.
    always_comb begin
        is_match = (rx_hdr_type        == ARP_HTYPE_ETH)  &&
                   (rx_proto_type      == ARP_PTYPE_IPV4) &&
                   (rx_hdr_addr_length == ARP_HLEN)       &&
                   (rx_pro_addr_length == ARP_PLEN)       &&
                   (rx_operation       == ARP_OP_REQUEST) &&
                   (rx_target_ip_addr  == LOCAL_IP);
    end

    // Next-state logic for the reply sequencer and statistics counters.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mac_d    = mac_q;
        ip_d     = ip_q;
        valid_d  = valid_q;
        last_d   = last_q;
        reply_d  = reply_q;
        ignore_d = ignore_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_match) begin
                        state_d = SEND;
                        idx_d   = '0;
                        mac_d   = rx_send_hdr_addr;
                        ip_d    = rx_send_ip_addr;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        ignore_d = ignore_q + CNT_ONE;
                    end
                end
            end
            SEND: begin
                if (req_valid) begin
                    drop_d = drop_q + CNT_ONE;
                end
                if (valid_q && tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        reply_d = reply_q + CNT_ONE;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        last_d = ((idx_q + 3'd1) == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    arp_word_mux u_word_mux (
        .idx_i       (idx_d),
        .local_mac_i (LOCAL_MAC),
        .local_ip_i  (LOCAL_IP),
        .peer_mac_i  (mac_d),
        .peer_ip_i   (ip_d),
        .word_o      (next_word)
    );

    // Drive zero on the data bus whenever no word is being presented.
    always_comb begin
        data_d = valid_d ? next_word : 32'h0;
    end

    // State register; reset aborts any reply in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mac_q    <= '0;
            ip_q     <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            reply_q  <= '0;
            ignore_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mac_q    <= mac_d;
            ip_q     <= ip_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            reply_q  <= reply_d;
            ignore_q <= ignore_d;
            drop_q   <= drop_d;
        end
    end

    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign tx_last    = last_q;
    assign busy       = (state_q != IDLE);
    assign reply_cnt  = reply_q;
    assign ignore_cnt = ignore_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Testbench for arp_reply_tx: table of packets, hand sequences for the
// multi-cycle corners, and a random run against a queue-based packet model.
module tb_arp_reply_tx;

    localparam logic [47:0] LMAC = 48'h000A35010203;
    localparam logic [31:0] LIP  = 32'hC0A8010A;

    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] op;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [31:0] tip;
    } pkt_t;

    typedef struct packed {
        pkt_t        p;
        logic        expReply;
        logic [31:0] expW5;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, req_valid, req2, tx_ready, ready2;
    logic [15:0] rx_hdr_type, rx_proto_type, rx_operation;
    logic [7:0]  rx_hdr_addr_length, rx_pro_addr_length;
    logic [47:0] rx_send_hdr_addr;
    logic [31:0] rx_send_ip_addr, rx_target_ip_addr;
    logic [31:0] tx_data, tx_data2;
    logic        tx_valid, tx_last, busy, tx_valid2, tx_last2, busy2;
    logic [15:0] reply_cnt, ignore_cnt, drop_cnt;
    logic [1:0]  reply_cnt2, ignore_cnt2, drop_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending reply words and counters.
    logic        mBusy;
    logic [31:0] mq[$];
    int          mRep, mIgn, mDrop;
    logic [31:0] got[$];
    logic [31:0] specW[7];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    arp_reply_tx dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .rx_hdr_type(rx_hdr_type), .rx_proto_type(rx_proto_type),
        .rx_hdr_addr_length(rx_hdr_addr_length), .rx_pro_addr_length(rx_pro_addr_length),
        .rx_operation(rx_operation), .rx_send_hdr_addr(rx_send_hdr_addr),
        .rx_send_ip_addr(rx_send_ip_addr), .rx_target_ip_addr(rx_target_ip_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .reply_cnt(reply_cnt), .ignore_cnt(ignore_cnt), .drop_cnt(drop_cnt)
    );

    arp_reply_tx #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req2),
        .rx_hdr_type(rx_hdr_type), .rx_proto_type(rx_proto_type),
        .rx_hdr_addr_length(rx_hdr_addr_length), .rx_pro_addr_length(rx_pro_addr_length),
        .rx_operation(rx_operation), .rx_send_hdr_addr(rx_send_hdr_addr),
        .rx_send_ip_addr(rx_send_ip_addr), .rx_target_ip_addr(rx_target_ip_addr),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(ready2), .tx_last(tx_last2),
        .busy(busy2), .reply_cnt(reply_cnt2), .ignore_cnt(ignore_cnt2), .drop_cnt(drop_cnt2)
    );

    function automatic pkt_t mkPkt(logic [15:0] ht, logic [15:0] pt, logic [7:0] hl,
                                   logic [7:0] pl, logic [15:0] op, logic [47:0] sm,
                                   logic [31:0] si, logic [31:0] ti);
        pkt_t p;
        p.htype = ht; p.ptype = pt; p.hlen = hl; p.plen = pl;
        p.op = op; p.smac = sm; p.sip = si; p.tip = ti;
        return p;
    endfunction

    function automatic logic isMatch(pkt_t p);
        return p.htype == 16'h0001 && p.ptype == 16'h0800 && p.hlen == 8'd6 &&
               p.plen == 8'd4 && p.op == 16'h0001 && p.tip == LIP;
    endfunction

    // The reply as the 28-byte ARP packet image, cut into big-endian words.
    function automatic void buildReply(logic [47:0] mac, logic [31:0] ip);
        logic [223:0] img;
        img = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, LMAC, LIP, mac, ip};
        mq.delete();
        for (int k = 0; k < 7; k++) mq.push_back(img[223 - 32*k -: 32]);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic tick(input logic r, input logic rq, input pkt_t p, input logic rdy);
        rst = r; req_valid = rq; tx_ready = rdy;
        rx_hdr_type = p.htype; rx_proto_type = p.ptype;
        rx_hdr_addr_length = p.hlen; rx_pro_addr_length = p.plen;
        rx_operation = p.op; rx_send_hdr_addr = p.smac;
        rx_send_ip_addr = p.sip; rx_target_ip_addr = p.tip;
        if (r) begin
            mBusy = 1'b0; mq.delete(); mRep = 0; mIgn = 0; mDrop = 0;
        end else if (!mBusy) begin
            if (rq) begin
                if (isMatch(p)) begin
                    buildReply(p.smac, p.sip);
                    mBusy = 1'b1;
                end else begin
                    mIgn++;
                end
            end
        end else begin
            if (rq) mDrop++;
            if (rdy) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    mBusy = 1'b0;
                    mRep++;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("txValid", tx_valid, mBusy);
        checkOutput("txData", tx_data, mBusy ? mq[0] : 32'h0);
        checkOutput("txLast", tx_last, mBusy && mq.size() == 1);
        checkOutput("busy", busy, mBusy);
        checkOutput("replyCnt", reply_cnt, 16'(mRep));
        checkOutput("ignoreCnt", ignore_cnt, 16'(mIgn));
        checkOutput("dropCnt", drop_cnt, 16'(mDrop));
    endtask

    // Pulse one packet and return with the first reply word (if any) showing.
    task automatic applyStimulus(input pkt_t p);
        tick(1'b0, 1'b1, p, 1'b1);
    endtask

    // Run a reply to completion with tx_ready high, collecting accepted words.
    task automatic drainReply(input pkt_t idle);
        got.delete();
        for (int c = 0; c < 20 && tx_valid; c++) begin
            got.push_back(tx_data);
            tick(1'b0, 1'b0, idle, 1'b1);
        end
    endtask

    task automatic checkSpecWords(input string name);
        checkOutput({name, "Len"}, got.size(), 7);
        for (int k = 0; k < 7 && k < got.size(); k++)
            checkOutput(name, got[k], specW[k]);
    endtask

    function automatic pkt_t randPkt(pkt_t base);
        pkt_t p;
        p = base;
        p.smac = 48'({$urandom(), $urandom()});
        p.sip  = $urandom();
        case ($urandom_range(0, 9))
            1: p.tip   = p.tip ^ (32'h1 << $urandom_range(0, 31));
            2: p.op    = 16'h0002;
            3: p.ptype = 16'h86DD;
            4: p.htype = 16'h0006;
            5: p.hlen  = 8'd8;
            6: p.plen  = 8'd16;
            default: ;
        endcase
        return p;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pkt_t pm, pOther, pBad;
        int expIgn;
        pm     = mkPkt(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h112233445566, 32'hC0A80105, LIP);
        pOther = mkPkt(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'hAABBCCDDEEFF, 32'hC0A80177, LIP);
        pBad   = mkPkt(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h112233445566, 32'hC0A80105, 32'hC0A80109);
        specW = '{32'h00010800, 32'h06040002, 32'h000A3501, 32'h0203C0A8,
                  32'h010A1122, 32'h33445566, 32'hC0A80105};
        vecs[0] = '{p: pm, expReply: 1'b1, expW5: 32'h33445566};
        vecs[1] = '{p: pBad, expReply: 1'b0, expW5: 32'h0};
        vecs[2] = '{p: mkPkt(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, 48'h112233445566, 32'hC0A80105, LIP),
                    expReply: 1'b0, expW5: 32'h0};
        vecs[3] = '{p: mkPkt(16'h0001, 16'h86DD, 8'd6, 8'd4, 16'h0001, 48'h112233445566, 32'hC0A80105, LIP),
                    expReply: 1'b0, expW5: 32'h0};
        vecs[4] = '{p: mkPkt(16'h0001, 16'h0800, 8'd5, 8'd4, 16'h0001, 48'h112233445566, 32'hC0A80105, LIP),
                    expReply: 1'b0, expW5: 32'h0};
        vecs[5] = '{p: pOther, expReply: 1'b1, expW5: 32'hCCDDEEFF};
        req2 = 1'b0; ready2 = 1'b1;
        mBusy = 1'b0; mRep = 0; mIgn = 0; mDrop = 0;

        // Reset state.
        tick(1'b1, 1'b0, pm, 1'b1);
        tick(1'b1, 1'b0, pm, 1'b1);
        checkOutput("rstValid", tx_valid, 1'b0);
        checkOutput("rstData", tx_data, 32'h0);
        checkOutput("rstCnt", {reply_cnt, ignore_cnt, drop_cnt}, 48'h0);
        tick(1'b0, 1'b0, pm, 1'b1);

        // Reference reply, one word per cycle from one clock after the pulse.
        applyStimulus(pm);
        for (int k = 0; k < 7; k++) begin
            checkOutput("specWord", tx_data, specW[k]);
            checkOutput("specLast", tx_last, k == 6);
            tick(1'b0, 1'b0, pm, 1'b1);
        end
        checkOutput("specDone", tx_valid, 1'b0);
        checkOutput("specReplyCnt", reply_cnt, 16'd1);

        // Table of packets: matching and non-matching variants.
        expIgn = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].p);
            checkOutput("vecValid", tx_valid, vecs[i].expReply);
            checkOutput("vecBusy", busy, vecs[i].expReply);
            if (vecs[i].expReply) begin
                drainReply(pm);
                checkOutput("vecLen", got.size(), 7);
                checkOutput("vecW5", got.size() > 5 ? got[5] : 32'hDEAD, vecs[i].expW5);
            end else begin
                expIgn++;
            end
            tick(1'b0, 1'b0, pm, 1'b1);
            checkOutput("vecIgn", ignore_cnt, 16'(expIgn));
        end

        // Backpressure: ready low while W2 is presented for three cycles.
        applyStimulus(pm);
        got.delete();
        for (int c = 0; c < 20 && tx_valid; c++) begin
            logic rdy;
            rdy = !(c >= 2 && c <= 4);
            if (c >= 2 && c <= 4) checkOutput("stallHold", tx_data, specW[2]);
            if (rdy) got.push_back(tx_data);
            tick(1'b0, 1'b0, pm, rdy);
        end
        checkSpecWords("bpWord");

        // Second matching request while W3 is presented is dropped.
        applyStimulus(pm);
        got.delete();
        for (int c = 0; c < 20 && tx_valid; c++) begin
            got.push_back(tx_data);
            tick(1'b0, c == 3, pOther, 1'b1);
        end
        checkSpecWords("dropWord");
        checkOutput("dropCnt1", drop_cnt, 16'd1);
        tick(1'b0, 1'b0, pm, 1'b1);
        tick(1'b0, 1'b0, pm, 1'b1);
        checkOutput("noSecondReply", tx_valid, 1'b0);

        // Reset while W4 is presented, then a clean reply.
        applyStimulus(pm);
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, pm, 1'b1);
        checkOutput("preRstW4", tx_data, specW[4]);
        tick(1'b1, 1'b0, pm, 1'b1);
        checkOutput("midRstValid", tx_valid, 1'b0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstCnt", {reply_cnt, ignore_cnt, drop_cnt}, 48'h0);
        tick(1'b0, 1'b0, pm, 1'b1);
        applyStimulus(pm);
        drainReply(pm);
        checkSpecWords("postRstWord");

        // Two-bit counters wrap: five ignored packets leave a count of one.
        for (int i = 0; i < 5; i++) begin
            req2 = 1'b1;
            tick(1'b0, 1'b0, pBad, 1'b1);
            req2 = 1'b0;
            tick(1'b0, 1'b0, pBad, 1'b1);
        end
        checkOutput("wrapIgn", ignore_cnt2, 2'd1);
        checkOutput("wrapNoTx", tx_valid2, 1'b0);

        // Random traffic against the packet model.
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, $urandom_range(0, 3) == 0, randPkt(pm), $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
